// File: rtl/cnn_pkg.sv
// Constants and helpers shared by the IFM feeder, the sliding-window line buffer
// and the convolution controller.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feeder_state_t;

    // Shifts needed before the oldest tap holds a pixel (two pixels per shift).
    function automatic int fill_shifts(input int fifo_size);
        return (fifo_size + 1) / 2;
    endfunction

    // Pixel index sitting on the top-left tap at the first full shift (0 or 1).
    function automatic int fill_tap(input int fifo_size);
        return 2 * fill_shifts(fifo_size) - fifo_size;
    endfunction

    localparam int CNN_DATA_WIDTH       = 32;
    localparam int CNN_IFM_SIZE         = 32;
    localparam int CNN_KERNAL_SIZE      = 5;
    localparam int CNN_FIFO_SIZE        = (CNN_KERNAL_SIZE - 1) * CNN_IFM_SIZE + CNN_KERNAL_SIZE;
    localparam int CNN_S0               = fill_shifts(CNN_FIFO_SIZE);
    localparam int CNN_T0               = fill_tap(CNN_FIFO_SIZE);
    localparam int CNN_IFM_SIZE_NEXT    = CNN_IFM_SIZE - CNN_KERNAL_SIZE + 1;
    localparam int CNN_ADDRESS_SIZE_IFM = $clog2(CNN_IFM_SIZE * CNN_IFM_SIZE);
    localparam int CNN_POS_BITS         = $clog2(CNN_IFM_SIZE);

endpackage

// File: rtl/ifm_window_feeder_window_position_tracker.sv
// Follows line-buffer shifts and reports where the window on the taps sits,
// flagging only complete windows that do not straddle an IFM row boundary.
module window_position_tracker
    import cnn_pkg::*;
#(
    parameter int IFM_SIZE    = CNN_IFM_SIZE,
    parameter int KERNAL_SIZE = CNN_KERNAL_SIZE,
    parameter int FIFO_SIZE   = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE,
    parameter int POS_BITS    = $clog2(IFM_SIZE),
    parameter int SW          = $clog2(IFM_SIZE * IFM_SIZE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                shift_i,
    output logic                valid_o,
    output logic                done_o,
    output logic [POS_BITS-1:0] row_o,
    output logic [POS_BITS-1:0] col_o
);

    localparam logic [SW-1:0]       S0_C   = SW'(fill_shifts(FIFO_SIZE));
    localparam logic [SW-1:0]       S_LAST = SW'(IFM_SIZE * IFM_SIZE / 2);
    localparam logic [POS_BITS-1:0] T0_C   = POS_BITS'(fill_tap(FIFO_SIZE));
    localparam logic [POS_BITS-1:0] LIM    = POS_BITS'(IFM_SIZE - KERNAL_SIZE);
    localparam logic [POS_BITS:0]   IFM_W  = (POS_BITS + 1)'(IFM_SIZE);
    localparam logic [POS_BITS:0]   STEP   = (POS_BITS + 1)'(2);

    logic [SW-1:0]       s_q, s_d;
    logic [POS_BITS-1:0] row_q, row_d, col_q, col_d;
    logic [POS_BITS-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic                valid_q, valid_d, done_q, done_d;
    logic [POS_BITS:0]   col_step;

    always_comb begin
        s_d       = s_q;
        row_d     = row_q;
        col_d     = col_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        col_step  = {1'b0, col_q} + STEP;
        if (clear_i) begin
            s_d   = '0;
            row_d = '0;
            col_d = '0;
        end else if (shift_i) begin
            s_d = s_q + SW'(1);
            if (s_d == S0_C) begin
                row_d = '0;
                col_d = T0_C;
            end else if (s_d > S0_C) begin
                // Tap position advances two pixels per shift, wrapping into the next row.
                if (col_step >= IFM_W) begin
                    col_d = POS_BITS'(col_step - IFM_W);
                    row_d = row_q + POS_BITS'(1);
                end else begin
                    col_d = col_step[POS_BITS-1:0];
                end
            end
            valid_d = (s_d >= S0_C) && (row_d <= LIM) && (col_d <= LIM);
            if (valid_d) begin
                win_row_d = row_d;
                win_col_d = col_d;
            end
            done_d = (s_d == S_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            s_q       <= s_d;
            row_q     <= row_d;
            col_q     <= col_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign row_o   = win_row_q;
    assign col_o   = win_col_q;

endmodule

// File: rtl/ifm_window_feeder.sv
// Streams one IFM channel from the dual-port RAM into the two-pixel line buffer
// and reports the window position on the buffer taps.
module ifm_window_feeder
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH       = CNN_DATA_WIDTH,
    parameter int IFM_SIZE         = CNN_IFM_SIZE,
    parameter int KERNAL_SIZE      = CNN_KERNAL_SIZE,
    parameter int FIFO_SIZE        = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int POS_BITS         = $clog2(IFM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        hold,
    output logic                        ifm_enable,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_1,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_2,
    output logic                        fifo_enable,
    output logic                        window_valid,
    output logic [POS_BITS-1:0]         window_row,
    output logic [POS_BITS-1:0]         window_col,
    output logic                        busy,
    output logic                        done,
    output feeder_state_t               dbg_state
);

    localparam int               KW     = ADDRESS_SIZE_IFM - 1;
    localparam logic [KW-1:0]    K_LAST = KW'(IFM_SIZE * IFM_SIZE / 2 - 1);

    if ((IFM_SIZE % 2) != 0 || DATA_WIDTH < 1) begin : g_param_check
        $error("ifm_window_feeder: IFM_SIZE must be even and DATA_WIDTH positive");
    end

    feeder_state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          fifo_en_q;
    logic          issue;
    logic          clear_track;
    logic          track_done;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        issue       = 1'b0;
        clear_track = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_STREAM;
                    k_d         = '0;
                    clear_track = 1'b1;
                end
            end
            ST_STREAM: begin
                if (!hold) begin
                    issue = 1'b1;
                    k_d   = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Last read is already in flight; leave once its window has been flagged.
                if (track_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            fifo_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            fifo_en_q <= issue;
        end
    end

    window_position_tracker #(
        .IFM_SIZE    (IFM_SIZE),
        .KERNAL_SIZE (KERNAL_SIZE),
        .FIFO_SIZE   (FIFO_SIZE),
        .POS_BITS    (POS_BITS),
        .SW          (ADDRESS_SIZE_IFM)
    ) u_tracker (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (clear_track),
        .shift_i (fifo_en_q),
        .valid_o (window_valid),
        .done_o  (track_done),
        .row_o   (window_row),
        .col_o   (window_col)
    );

    assign ifm_enable    = issue;
    assign ifm_address_1 = (state_q == ST_STREAM) ? {k_q, 1'b0} : '0;
    assign ifm_address_2 = (state_q == ST_STREAM) ? {k_q, 1'b1} : '0;
    assign fifo_enable   = fifo_en_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = track_done;
    assign dbg_state     = state_q;

endmodule
